// File: rtl/seq_control_unit_if.sv
// ID-stage control bundle between the decode stage (master) and the
// sequencing control unit (slave): instruction fields in, control out.
interface seq_control_unit_if #(
  parameter int NUM_REGS = 16,
  parameter int CMD_W    = 4,
  parameter int OFF_W    = 8
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic                freeze;
  logic                instr_valid;
  logic [1:0]          mode;
  logic [3:0]          opcode;
  logic                s_in;
  logic [NUM_REGS-1:0] reg_list;

  logic                b;
  logic                s_out;
  logic                wb_en;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [CMD_W-1:0]    exe_cmd;
  logic [REG_W-1:0]    xfer_reg;
  logic [OFF_W-1:0]    addr_offset;
  logic                stall;

  modport master (
    output freeze, instr_valid, mode, opcode, s_in, reg_list,
    input  b, s_out, wb_en, mem_r_en, mem_w_en, exe_cmd, xfer_reg,
           addr_offset, stall
  );

  modport slave (
    input  freeze, instr_valid, mode, opcode, s_in, reg_list,
    output b, s_out, wb_en, mem_r_en, mem_w_en, exe_cmd, xfer_reg,
           addr_offset, stall
  );
endinterface

// File: rtl/seq_control_unit.sv
// ID-stage control unit with sequencing for block transfers (LDM/STM),
// one memory beat per cycle in ascending register order.
// Optional feature macro: MULTI_CYCLE_MUL_EN adds a multi-cycle MUL
// (mode 11, opcode 0000) lasting MUL_LATENCY cycles.
module seq_control_unit #(
  parameter int NUM_REGS = 16,
  parameter int CMD_W    = 4,
  parameter int OFF_W    = 8
`ifdef MULTI_CYCLE_MUL_EN
  , parameter int MUL_LATENCY = 3
`endif
) (
  input logic              clk,
  input logic              rst,
  seq_control_unit_if.slave bus
);
  localparam int REG_W = $clog2(NUM_REGS);

`ifdef MULTI_CYCLE_MUL_EN
  localparam int CNT_W = $clog2(MUL_LATENCY);
  typedef enum logic [1:0] {IDLE, XFER, MUL} state_t;
  logic [CNT_W-1:0] mul_cnt, mul_cnt_next;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t              state, state_next;
  logic [NUM_REGS-1:0] pending, pending_next;
  logic [REG_W-1:0]    beat, beat_next;
  logic                is_load, is_load_next;
  logic [NUM_REGS-1:0] first_rest;
  logic [NUM_REGS-1:0] pend_rest;

  // Index of the lowest set bit; the loop runs downward so the lowest wins.
  function automatic logic [REG_W-1:0] lowest_index(input logic [NUM_REGS-1:0] v);
    lowest_index = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = REG_W'(i);
    end
  endfunction

  // Byte offset of a beat: four bytes per register, wrapping at OFF_W bits.
  function automatic logic [OFF_W-1:0] beat_offset(input logic [REG_W-1:0] idx);
    beat_offset = OFF_W'({idx, 2'b00});
  endfunction

  // Register lists with their lowest bit removed (the beat being issued now).
  assign first_rest = bus.reg_list & (bus.reg_list - NUM_REGS'(1));
  assign pend_rest  = pending & (pending - NUM_REGS'(1));

  // Sequencer state; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      beat    <= '0;
      is_load <= 1'b0;
`ifdef MULTI_CYCLE_MUL_EN
      mul_cnt <= '0;
`endif
    end else begin
      state   <= state_next;
      pending <= pending_next;
      beat    <= beat_next;
      is_load <= is_load_next;
`ifdef MULTI_CYCLE_MUL_EN
      mul_cnt <= mul_cnt_next;
`endif
    end
  end

  // Decode, beat issue and next-state selection; everything stays 0 under reset.
  always_comb begin
    bus.b           = 1'b0;
    bus.s_out       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.mem_r_en    = 1'b0;
    bus.mem_w_en    = 1'b0;
    bus.exe_cmd     = '0;
    bus.xfer_reg    = '0;
    bus.addr_offset = '0;
    bus.stall       = 1'b0;
    state_next      = state;
    pending_next    = pending;
    beat_next       = beat;
    is_load_next    = is_load;
`ifdef MULTI_CYCLE_MUL_EN
    mul_cnt_next    = mul_cnt;
`endif
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.instr_valid && !bus.freeze) begin
            bus.b = (bus.mode == 2'b10);
            case (bus.mode)
              2'b00: begin
                bus.wb_en = 1'b1;
                bus.s_out = bus.s_in;
                case (bus.opcode)
                  4'hD: bus.exe_cmd = CMD_W'(4'd1);
                  4'hF: bus.exe_cmd = CMD_W'(4'd9);
                  4'h4: bus.exe_cmd = CMD_W'(4'd2);
                  4'h5: bus.exe_cmd = CMD_W'(4'd3);
                  4'h2: bus.exe_cmd = CMD_W'(4'd4);
                  4'h6: bus.exe_cmd = CMD_W'(4'd5);
                  4'h0: bus.exe_cmd = CMD_W'(4'd6);
                  4'hC: bus.exe_cmd = CMD_W'(4'd7);
                  4'h1: bus.exe_cmd = CMD_W'(4'd8);
                  4'hA: begin
                    bus.exe_cmd = CMD_W'(4'd4);
                    bus.wb_en   = 1'b0;
                  end
                  4'h8: begin
                    bus.exe_cmd = CMD_W'(4'd6);
                    bus.wb_en   = 1'b0;
                  end
                  default: begin
                    bus.wb_en = 1'b0;
                    bus.s_out = 1'b0;
                  end
                endcase
              end
              2'b01: begin
                if (bus.opcode == 4'b0010) begin
                  bus.exe_cmd  = CMD_W'(4'd2);
                  bus.mem_r_en = !bus.s_in;
                  bus.wb_en    = !bus.s_in;
                  bus.mem_w_en = bus.s_in;
                end else if (bus.opcode == 4'b0100 && bus.reg_list != '0) begin
                  bus.exe_cmd  = CMD_W'(4'd2);
                  bus.xfer_reg = lowest_index(bus.reg_list);
                  bus.mem_r_en = bus.s_in;
                  bus.wb_en    = bus.s_in;
                  bus.mem_w_en = !bus.s_in;
                  if (first_rest != '0) begin
                    bus.stall    = 1'b1;
                    pending_next = first_rest;
                    beat_next    = REG_W'(1);
                    is_load_next = bus.s_in;
                    state_next   = XFER;
                  end
                end
              end
`ifdef MULTI_CYCLE_MUL_EN
              2'b11: begin
                if (bus.opcode == 4'b0000) begin
                  bus.exe_cmd  = CMD_W'(4'b1010);
                  bus.stall    = 1'b1;
                  mul_cnt_next = CNT_W'(MUL_LATENCY - 1);
                  state_next   = MUL;
                end
              end
`endif
              default: ;
            endcase
          end
        end
        XFER: begin
          if (bus.freeze) begin
            bus.stall = 1'b1;
          end else begin
            bus.exe_cmd     = CMD_W'(4'd2);
            bus.xfer_reg    = lowest_index(pending);
            bus.addr_offset = beat_offset(beat);
            bus.mem_r_en    = is_load;
            bus.wb_en       = is_load;
            bus.mem_w_en    = !is_load;
            pending_next    = pend_rest;
            if (pend_rest != '0) begin
              bus.stall = 1'b1;
              beat_next = beat + REG_W'(1);
            end else begin
              beat_next  = '0;
              state_next = IDLE;
            end
          end
        end
`ifdef MULTI_CYCLE_MUL_EN
        MUL: begin
          if (bus.freeze) begin
            bus.stall = 1'b1;
          end else begin
            bus.exe_cmd = CMD_W'(4'b1010);
            if (mul_cnt == CNT_W'(1)) begin
              bus.wb_en    = 1'b1;
              mul_cnt_next = '0;
              state_next   = IDLE;
            end else begin
              bus.stall    = 1'b1;
              mul_cnt_next = mul_cnt - CNT_W'(1);
            end
          end
        end
`endif
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_seq_control_unit;
  localparam int MUL_LAT = 3;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  seq_control_unit_if #(.NUM_REGS(16), .CMD_W(4), .OFF_W(8)) bus_if ();

  seq_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs outputs as {b,s_out,wb,mem_r,mem_w,exe[4],xfer[4],off[8],stall}.
  function automatic logic [21:0] pk(bit b, bit s, bit wb, bit mr, bit mw,
                                     int exe, int xr, int off, bit st);
    logic [3:0] e4;
    logic [3:0] x4;
    logic [7:0] o8;
    e4 = 4'(exe);
    x4 = 4'(xr);
    o8 = 8'(off);
    return {b, s, wb, mr, mw, e4, x4, o8, st};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {bus_if.b, bus_if.s_out, bus_if.wb_en, bus_if.mem_r_en,
            bus_if.mem_w_en, bus_if.exe_cmd, bus_if.xfer_reg,
            bus_if.addr_offset, bus_if.stall};
  endfunction

  // ALU command table for mode 00; -1 marks an undefined opcode.
  function automatic int cmd_of(logic [3:0] op);
    case (op)
      4'hD: return 1;
      4'hF: return 9;
      4'h4: return 2;
      4'h5: return 3;
      4'h2: return 4;
      4'h6: return 5;
      4'h0: return 6;
      4'hC: return 7;
      4'h1: return 8;
      4'hA: return 4;
      4'h8: return 6;
      default: return -1;
    endcase
  endfunction

  // Reference model state: remaining beats as a queue of register numbers.
  int mq[$];
  int m_beat;
  bit m_ld;
  int m_mul;
  bit e_b, e_s, e_wb, e_mr, e_mw, e_st;
  int e_exe, e_xr, e_off;

  task automatic model_issue();
    e_xr  = mq.pop_front();
    e_exe = 2;
    e_off = (m_beat * 4) % 256;
    e_wb  = m_ld;
    e_mr  = m_ld;
    e_mw  = !m_ld;
    e_st  = (mq.size() > 0);
    m_beat++;
  endtask

  // Model step and comparison on every falling edge.
  initial begin
    logic [21:0] exp_v;
    int c;
    m_beat = 0;
    m_ld   = 0;
    m_mul  = 0;
    forever begin
      @(negedge clk);
      {e_b, e_s, e_wb, e_mr, e_mw, e_st} = '0;
      e_exe = 0;
      e_xr  = 0;
      e_off = 0;
      if (rst) begin
        mq.delete();
        m_mul = 0;
      end else if (mq.size() > 0) begin
        if (bus_if.freeze) e_st = 1;
        else model_issue();
      end else if (m_mul > 0) begin
        if (bus_if.freeze) e_st = 1;
        else begin
          e_exe = 10;
          m_mul--;
          e_st  = (m_mul > 0);
          e_wb  = (m_mul == 0);
        end
      end else if (bus_if.instr_valid && !bus_if.freeze) begin
        e_b = (bus_if.mode == 2'b10);
        if (bus_if.mode == 2'b00) begin
          c = cmd_of(bus_if.opcode);
          if (c >= 0) begin
            e_exe = c;
            e_s   = bus_if.s_in;
            e_wb  = (bus_if.opcode != 4'hA) && (bus_if.opcode != 4'h8);
          end
        end else if (bus_if.mode == 2'b01) begin
          if (bus_if.opcode == 4'b0010) begin
            e_exe = 2;
            e_mr  = !bus_if.s_in;
            e_wb  = !bus_if.s_in;
            e_mw  = bus_if.s_in;
          end else if (bus_if.opcode == 4'b0100) begin
            for (int i = 0; i < 16; i++)
              if (bus_if.reg_list[i]) mq.push_back(i);
            if (mq.size() > 0) begin
              m_ld   = bus_if.s_in;
              m_beat = 0;
              model_issue();
            end
          end
        end
`ifdef MULTI_CYCLE_MUL_EN
        else if (bus_if.mode == 2'b11 && bus_if.opcode == 4'b0000) begin
          e_exe = 10;
          e_st  = 1;
          m_mul = MUL_LAT - 1;
        end
`endif
      end
      exp_v = pk(e_b, e_s, e_wb, e_mr, e_mw, e_exe, e_xr, e_off, e_st);
      checks++;
      if (dut_vec() !== exp_v) begin
        errors++;
        $display("[TB] FAIL model_cycle t=%0t got=%h expected=%h", $time, dut_vec(), exp_v);
      end
    end
  end

  // Drives one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [1:0] m,
                               input logic [3:0] op, input bit s,
                               input logic [15:0] rl, input bit fz);
    @(posedge clk);
    #1;
    rst                = r;
    bus_if.instr_valid = v;
    bus_if.mode        = m;
    bus_if.opcode      = op;
    bus_if.s_in        = s;
    bus_if.reg_list    = rl;
    bus_if.freeze      = fz;
  endtask

  // Literal check of the outputs for the cycle just driven.
  task automatic checkOutput(input string name, input logic [21:0] exp_v);
    @(negedge clk);
    #1;
    checks++;
    if (dut_vec() !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, dut_vec(), exp_v);
    end
  endtask

  // Directed scenarios.
  initial begin
    rst                = 1'b1;
    bus_if.instr_valid = 1'b1;
    bus_if.mode        = 2'b00;
    bus_if.opcode      = 4'hD;
    bus_if.s_in        = 1'b1;
    bus_if.reg_list    = '0;
    bus_if.freeze      = 1'b0;

    applyStimulus(1, 1, 2'b00, 4'hD, 1, 16'h0, 0);
    checkOutput("reset_zero", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // mode 00 decode sweep
    for (int op = 0; op < 16; op++) begin
      applyStimulus(0, 1, 2'b00, 4'(op), 1, 16'h0, 0);
      case (op)
        13: checkOutput("mov", pk(0, 1, 1, 0, 0, 1, 0, 0, 0));
        10: checkOutput("cmp", pk(0, 1, 0, 0, 0, 4, 0, 0, 0));
        8:  checkOutput("tst", pk(0, 1, 0, 0, 0, 6, 0, 0, 0));
        3:  checkOutput("undef_op3", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        15: checkOutput("mvn", pk(0, 1, 1, 0, 0, 9, 0, 0, 0));
        default: ;
      endcase
    end

    applyStimulus(0, 0, 2'b00, 4'hD, 1, 16'h0, 0);
    checkOutput("invalid_zero", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'b00, 4'hD, 1, 16'h0, 1);
    checkOutput("idle_freeze_zero", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'b10, 4'h0, 1, 16'h0, 0);
    checkOutput("branch", pk(1, 0, 0, 0, 0, 0, 0, 0, 0));

    // LDR then STR
    applyStimulus(0, 1, 2'b01, 4'b0010, 0, 16'h0, 0);
    checkOutput("ldr", pk(0, 0, 1, 1, 0, 2, 0, 0, 0));
    applyStimulus(0, 1, 2'b01, 4'b0010, 1, 16'h0, 0);
    checkOutput("str", pk(0, 0, 0, 0, 1, 2, 0, 0, 0));

    // LDM 8005: regs 0, 2, 15
    applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'h8005, 0);
    checkOutput("ldm_beat0", pk(0, 0, 1, 1, 0, 2, 0, 0, 1));
    applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'h8005, 0);
    checkOutput("ldm_beat1", pk(0, 0, 1, 1, 0, 2, 2, 4, 1));
    applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'h8005, 0);
    checkOutput("ldm_beat2", pk(0, 0, 1, 1, 0, 2, 15, 8, 0));

    // STM 0003 with a two-cycle freeze on beat 1
    applyStimulus(0, 1, 2'b01, 4'b0100, 0, 16'h0003, 0);
    checkOutput("stm_beat0", pk(0, 0, 0, 0, 1, 2, 0, 0, 1));
    applyStimulus(0, 1, 2'b01, 4'b0100, 0, 16'h0003, 1);
    checkOutput("stm_frozen1", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'b01, 4'b0100, 0, 16'h0003, 1);
    checkOutput("stm_frozen2", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'b01, 4'b0100, 0, 16'h0003, 0);
    checkOutput("stm_beat1", pk(0, 0, 0, 0, 1, 2, 1, 4, 0));
    applyStimulus(0, 1, 2'b00, 4'hD, 0, 16'h0, 0);
    checkOutput("mov_after_stm", pk(0, 0, 1, 0, 0, 1, 0, 0, 0));

    // single-beat and empty block transfers
    applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'h0010, 0);
    checkOutput("ldm_k1", pk(0, 0, 1, 1, 0, 2, 4, 0, 0));
    applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'h0000, 0);
    checkOutput("ldm_k0", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // STM FFFF cut by reset after beat 5
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 2'b01, 4'b0100, 0, 16'hFFFF, 0);
    checkOutput("stm_full_beat5", pk(0, 0, 0, 0, 1, 2, 5, 20, 1));
    applyStimulus(1, 1, 2'b01, 4'b0100, 0, 16'hFFFF, 0);
    checkOutput("stm_reset_zero", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 2'b00, 4'hD, 1, 16'h0, 0);
    checkOutput("mov_after_reset", pk(0, 1, 1, 0, 0, 1, 0, 0, 0));

    // full 16-beat LDM
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, 2'b01, 4'b0100, 1, 16'hFFFF, 0);
    checkOutput("ldm_full_last", pk(0, 0, 1, 1, 0, 2, 15, 60, 0));

    // mode 11
`ifdef MULTI_CYCLE_MUL_EN
    applyStimulus(0, 1, 2'b11, 4'b0000, 0, 16'h0, 0);
    checkOutput("mul_c0", pk(0, 0, 0, 0, 0, 10, 0, 0, 1));
    applyStimulus(0, 1, 2'b11, 4'b0000, 0, 16'h0, 1);
    checkOutput("mul_frozen", pk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(0, 1, 2'b11, 4'b0000, 0, 16'h0, 0);
    checkOutput("mul_c1", pk(0, 0, 0, 0, 0, 10, 0, 0, 1));
    applyStimulus(0, 1, 2'b11, 4'b0000, 0, 16'h0, 0);
    checkOutput("mul_c2", pk(0, 0, 1, 0, 0, 10, 0, 0, 0));
`else
    applyStimulus(0, 1, 2'b11, 4'b0000, 0, 16'h0, 0);
    checkOutput("mul_nop", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
    applyStimulus(0, 1, 2'b11, 4'b0001, 0, 16'h0, 0);
    checkOutput("mode11_nop", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 2'b00, 4'h0, 0, 16'h0, 0);
    checkOutput("final_idle", pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
